// File: rtl/axi4lite_slave_regs.sv
// axi4lite_slave_regs: AXI4-Lite slave with three read/write registers and a
// read-only ID register at word address 3. AW and W may arrive in any order or
// together; the write commits one cycle after both are held. Reads have a
// fixed latency of one cycle and run independently of the write path.
module axi4lite_slave_regs #(
    parameter int                    ADDR_WIDTH = 2,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    // AW channel
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    // W channel
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    // B channel
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    // AR channel
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    // R channel
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    // Live register contents, reg0 in the LSBs
    output logic [3*DATA_WIDTH-1:0]   regs_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int NUM_RW     = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HAVE_A = 3'd1,
        ST_HAVE_W = 3'd2,
        ST_COMMIT = 3'd3,
        ST_RESP   = 3'd4
    } wr_state_t;

    wr_state_t               state_r;
    logic [DATA_WIDTH-1:0]   regs_r [0:NUM_RW-1];
    logic [ADDR_WIDTH-1:0]   aw_addr_r;
    logic [DATA_WIDTH-1:0]   w_data_r;
    logic [STRB_WIDTH-1:0]   w_strb_r;
    logic                    awready_r;
    logic                    wready_r;
    logic                    bvalid_r;
    logic [1:0]              bresp_r;

    logic                    arready_r;
    logic                    rvalid_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [1:0]              rresp_r;

    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    ar_hs_s;
    logic                    r_hs_s;
    logic                    wr_ok_s;
    logic [DATA_WIDTH-1:0]   rd_mux_s;

    assign aw_hs_s = s_awvalid & awready_r;
    assign w_hs_s  = s_wvalid  & wready_r;
    assign ar_hs_s = s_arvalid & arready_r;
    assign r_hs_s  = rvalid_r  & s_rready;
    // Only the read/write registers accept writes; anything above is an error.
    assign wr_ok_s = (aw_addr_r < ADDR_WIDTH'(NUM_RW));

    // Read data selection from the address presented on AR.
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        case (s_araddr)
            ADDR_WIDTH'(0): rd_mux_s = regs_r[0];
            ADDR_WIDTH'(1): rd_mux_s = regs_r[1];
            ADDR_WIDTH'(2): rd_mux_s = regs_r[2];
            ADDR_WIDTH'(3): rd_mux_s = ID_VALUE;
            default:        rd_mux_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Write FSM: latches AW and W independently, commits, then holds the B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            aw_addr_r <= {ADDR_WIDTH{1'b0}};
            w_data_r  <= {DATA_WIDTH{1'b0}};
            w_strb_r  <= {STRB_WIDTH{1'b0}};
            for (int r = 0; r < NUM_RW; r++) begin
                regs_r[r] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s && w_hs_s) begin
                        aw_addr_r <= s_awaddr;
                        w_data_r  <= s_wdata;
                        w_strb_r  <= s_wstrb;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        state_r   <= ST_COMMIT;
                    end else if (aw_hs_s) begin
                        aw_addr_r <= s_awaddr;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        state_r   <= ST_HAVE_A;
                    end else if (w_hs_s) begin
                        w_data_r  <= s_wdata;
                        w_strb_r  <= s_wstrb;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b0;
                        state_r   <= ST_HAVE_W;
                    end else begin
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                ST_HAVE_A: begin
                    awready_r <= 1'b0;
                    if (w_hs_s) begin
                        w_data_r <= s_wdata;
                        w_strb_r <= s_wstrb;
                        wready_r <= 1'b0;
                        state_r  <= ST_COMMIT;
                    end else begin
                        wready_r <= 1'b1;
                    end
                end
                ST_HAVE_W: begin
                    wready_r <= 1'b0;
                    if (aw_hs_s) begin
                        aw_addr_r <= s_awaddr;
                        awready_r <= 1'b0;
                        state_r   <= ST_COMMIT;
                    end else begin
                        awready_r <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b1;
                    state_r   <= ST_RESP;
                    if (wr_ok_s) begin
                        bresp_r <= RESP_OKAY;
                        for (int r = 0; r < NUM_RW; r++) begin
                            if (aw_addr_r == ADDR_WIDTH'(r)) begin
                                for (int l = 0; l < STRB_WIDTH; l++) begin
                                    if (w_strb_r[l]) begin
                                        regs_r[r][8*l +: 8] <= w_data_r[8*l +: 8];
                                    end
                                end
                            end
                        end
                    end else begin
                        bresp_r <= RESP_SLVERR;
                    end
                end
                ST_RESP: begin
                    if (s_bready) begin
                        bvalid_r  <= 1'b0;
                        bresp_r   <= RESP_OKAY;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    bresp_r   <= RESP_OKAY;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Read path: capture data on AR handshake, hold it until the R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else if (rvalid_r) begin
            if (r_hs_s) begin
                rvalid_r  <= 1'b0;
                arready_r <= 1'b1;
            end else begin
                arready_r <= 1'b0;
            end
        end else if (ar_hs_s) begin
            rdata_r   <= rd_mux_s;
            rresp_r   <= RESP_OKAY;
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
        end else begin
            arready_r <= 1'b1;
        end
    end

    assign s_awready = awready_r;
    assign s_wready  = wready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_arready = arready_r;
    assign s_rvalid  = rvalid_r;
    assign s_rdata   = rdata_r;
    assign s_rresp   = rresp_r;
    assign regs_o    = {regs_r[2], regs_r[1], regs_r[0]};

endmodule
